// File: rtl/hack_pkg.sv
// Shared Hack platform constants and the UART receiver state encoding.
package hack_pkg;
  localparam int RAM_WORDS = 4096;
  localparam int LED_ADDR  = 8192;
  localparam int BUT_ADDR  = 8193;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling FSM, LSB-first shift register.
// byte_valid / frame_bad are single-cycle pulses decoded on the stop-sample cycle.
module uart_rx_byte
  import hack_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_bad,
  output rx_state_t  state
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  logic            r_rx_meta;
  logic            r_rx_sync;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_tick = (r_cnt == FULL_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!r_rx_sync) r_state <= START;
        end
        START: begin
          // Half a bit in: a line that went high again was only a glitch.
          if (r_cnt == HALF_CNT) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_sync ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_state <= STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign byte_valid = (r_state == STOP) && w_tick && r_rx_sync;
  assign frame_bad  = (r_state == STOP) && w_tick && !r_rx_sync;
  assign byte_data  = r_shift;
  assign state      = r_state;
endmodule

// File: rtl/uart_loader.sv
// UART boot loader: pairs received bytes into 16-bit words (high byte first) and
// writes them to consecutive RAM addresses from 0 until the last word is written.
module uart_loader #(
  parameter int CLKS_PER_BIT = 217,
  parameter int RAM_WORDS    = hack_pkg::RAM_WORDS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  input  logic                start,
  output logic [15:0]         address,
  output logic [15:0]         dataW,
  output logic                load,
  output logic                active,
  output logic                full,
  output logic                frame_err,
  output hack_pkg::rx_state_t dbg_rx_state
);
  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_WORDS - 1);

  logic          w_byte_valid;
  logic [7:0]    w_byte_data;
  logic          w_frame_bad;

  logic [AW-1:0] r_addr;
  logic [15:0]   r_data;
  logic          r_load;
  logic          r_active;
  logic          r_full;
  logic          r_frame_err;
  logic          r_phase_low;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .frame_bad  (w_frame_bad),
    .state      (dbg_rx_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_load      <= 1'b0;
      r_active    <= 1'b0;
      r_full      <= 1'b0;
      r_frame_err <= 1'b0;
      r_phase_low <= 1'b0;
    end else begin
      r_load <= 1'b0;
      if (start) begin
        r_addr      <= '0;
        r_phase_low <= 1'b0;
        r_full      <= 1'b0;
        r_frame_err <= 1'b0;
        r_active    <= 1'b1;
      end else begin
        // The address advances the cycle after the strobe; the last word saturates.
        if (r_load) begin
          if (r_addr == LAST_ADDR) begin
            r_full   <= 1'b1;
            r_active <= 1'b0;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        if (w_frame_bad) begin
          r_frame_err <= 1'b1;
          r_phase_low <= 1'b0;
        end else if (w_byte_valid && r_active && !r_full) begin
          if (!r_phase_low) begin
            r_data[15:8] <= w_byte_data;
            r_phase_low  <= 1'b1;
          end else begin
            r_data[7:0]  <= w_byte_data;
            r_load       <= 1'b1;
            r_phase_low  <= 1'b0;
          end
        end
      end
    end
  end

  assign address   = 16'(r_addr);
  assign dataW     = r_data;
  assign load      = r_load;
  assign active    = r_active;
  assign full      = r_full;
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: expected {address,dataW} pairs are queued as
// stimulus is issued; a monitor pops one entry per load strobe and compares.
module tb_uart_loader;
  localparam int CPB   = 8;
  localparam int WORDS = 4;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        start;
  logic [15:0] address;
  logic [15:0] dataW;
  logic        load;
  logic        active;
  logic        full;
  logic        frame_err;
  hack_pkg::rx_state_t dbg_rx_state;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_pass;
  logic        prev_load;

  uart_loader #(.CLKS_PER_BIT(CPB), .RAM_WORDS(WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .start        (start),
    .address      (address),
    .dataW        (dataW),
    .load         (load),
    .active       (active),
    .full         (full),
    .frame_err    (frame_err),
    .dbg_rx_state (dbg_rx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && load) begin
      n_checks++;
      if (prev_load) begin
        $display("FAIL load_spacing: got back-to-back load required single-cycle strobe");
      end else if (exp_q.size() == 0) begin
        $display("FAIL unexpected_load: got addr=%h data=%h required no load", address, dataW);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({address, dataW} === e) n_pass++;
        else $display("FAIL load_word: got addr=%h data=%h required addr=%h data=%h",
                      address, dataW, e[31:16], e[15:0]);
      end
    end
    prev_load <= load;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // driver tasks
  task automatic hold_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_bit);
    hold_bit(1'b1);
    hold_bit(1'b1);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_load(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (load) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s: got no load within 400 cycles required load", name);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    prev_load = 1'b0;
    rx        = 1'b1;
    start     = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_address", 32'(address), 32'h0);
    check("reset_load_active_full_ferr", {28'h0, load, active, full, frame_err}, 32'h0);
    check("reset_state", 32'(dbg_rx_state), 32'(hack_pkg::IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // word 0x1234 at address 0, address advances the cycle after load
    pulse_start();
    @(negedge clk);
    check("start_active", 32'(active), 32'h1);
    exp_q.push_back({16'h0000, 16'h1234});
    send_byte(8'h12, 1'b1);
    fork
      send_byte(8'h34, 1'b1);
      begin
        wait_load("t1_load");
        @(negedge clk);
        check("t1_addr_after_load", 32'(address), 32'h1);
      end
    join

    // framing error drops the byte and resynchronizes the byte phase
    pulse_start();
    @(negedge clk);
    check("start_addr_zero", 32'(address), 32'h0);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b0);
    check("frame_err_set", 32'(frame_err), 32'h1);
    exp_q.push_back({16'h0000, 16'hEF01});
    send_byte(8'hEF, 1'b1);
    send_byte(8'h01, 1'b1);
    check("frame_err_sticky", 32'(frame_err), 32'h1);

    // fill RAM, then further words are dropped
    pulse_start();
    @(negedge clk);
    check("start_clears_ferr", 32'(frame_err), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back({16'(i - 1), 16'(i)});
      send_byte(8'h00, 1'b1);
      send_byte(8'(i), 1'b1);
    end
    check("full_set", 32'(full), 32'h1);
    check("active_clear", 32'(active), 32'h0);
    check("addr_held_last", 32'(address), 32'h3);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("addr_held_after_extra", 32'(address), 32'h3);
    check("full_sticky", 32'(full), 32'h1);

    // short low glitch while idle
    pulse_start();
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch_no_ferr", 32'(frame_err), 32'h0);
    check("glitch_addr", 32'(address), 32'h0);
    check("glitch_state_idle", 32'(dbg_rx_state), 32'(hack_pkg::IDLE));

    // start during reception re-arms phase: the in-flight byte becomes the HIGH byte
    send_byte(8'h55, 1'b1);
    exp_q.push_back({16'h0000, 16'h6677});
    fork
      send_byte(8'h66, 1'b1);
      begin
        repeat (30) @(posedge clk);
        pulse_start();
      end
    join
    send_byte(8'h77, 1'b1);
    check("restart_addr", 32'(address), 32'h1);

    // reset mid-byte
    pulse_start();
    fork
      send_byte(8'hAA, 1'b1);
      begin
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
      end
    join
    @(negedge clk);
    check("midrst_address", 32'(address), 32'h0);
    check("midrst_dataW", 32'(dataW), 32'h0);
    check("midrst_flags", {28'h0, load, active, full, frame_err}, 32'h0);
    check("midrst_state", 32'(dbg_rx_state), 32'(hack_pkg::IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_start();
    exp_q.push_back({16'h0000, 16'h8000});
    send_byte(8'h80, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (10) @(posedge clk);

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
# uart_loader

Serial program/data loader that receives 8N1 UART bytes, pairs them into 16-bit Hack words (high byte first) and writes them into the 4K-word data RAM through the memory block's write port. It sits directly upstream of the memory block: its `address`, `dataW` and `load` outputs drive the memory's write inputs, either muxed with the CPU or exclusively during boot. Addresses auto-increment from 0 and stop at the top of RAM.

## Interface
- `CLKS_PER_BIT`, 217, clock cycles per UART bit (25 MHz / 115200); must be ≥ 4.
- `RAM_WORDS`, 4096, number of writable words; the last address is `RAM_WORDS-1`.
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART receive line, idle high, asynchronous to `clk`.
- `start`  in  1  one-cycle pulse: clear the address counter, byte phase and flags; begin a new load.
- `address`  out  16  write address to memory; bits [15:12] are always 0.
- `dataW`  out  16  assembled word.
- `load`  out  1  one-cycle write strobe to memory.
- `active`  out  1  high from `start` until full.
- `full`  out  1  sticky; `RAM_WORDS` words have been written.
- `frame_err`  out  1  sticky; a stop bit was sampled low.

## Operation
- Reset values: `address`=0, `dataW`=0, `load`=0, `active`=0, `full`=0, `frame_err`=0; RX FSM in IDLE; byte phase HIGH.
- `rx` passes through a 2-FF synchronizer, reset to 1.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronized low starts the bit counter → START.
  - START: at `CLKS_PER_BIT/2` the line is resampled; if it is low → DATA, if it is high (glitch) → IDLE with no byte emitted.
  - DATA: 8 samples, each `CLKS_PER_BIT` apart, shifted in LSB first → STOP.
  - STOP: one sample `CLKS_PER_BIT` later. High: the byte is valid. Low: `frame_err` is set, the byte is discarded and the byte phase is forced to HIGH. Either way → IDLE, which is entered on the same cycle as the stop sample.
- Bytes are received and framed regardless of `active`. They are only used when `active`=1 and `full`=0; otherwise they are dropped.
- Word assembly:
  - A HIGH-phase byte is stored in `dataW[15:8]`, then phase becomes LOW.
  - A LOW-phase byte is stored in `dataW[7:0]`, `load` is pulsed, then phase becomes HIGH.
- After each `load`, `address` increments. If the written address was `RAM_WORDS-1`, the block instead sets `full`, clears `active` and holds `address` at `RAM_WORDS-1`.
- `start` takes priority over everything on the same cycle:
  - `address`=0, phase HIGH, `full`=0, `frame_err`=0, `active`=1.
  - Any `load` due on that cycle is suppressed.
  - A byte currently in reception continues and is used as the HIGH byte of word 0.
- Reset mid-byte: the FSM returns to IDLE immediately and the partial byte is lost.

## Timing
- Falling edge of the start bit to valid byte: about `9.5*CLKS_PER_BIT` + 2 synchronizer cycles.
- `load` rises on the cycle after the valid stop sample of the LOW byte.
- `address` and `dataW` are stable for the whole `load` cycle.
- `address` changes on the cycle after `load`.
- `load` is never high on two consecutive cycles. Minimum spacing is 20 bit times.
- `full` and the `active` drop both become visible on the cycle after the final `load`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- The shared package `hack_pkg` holds:
  - `RAM_WORDS`, `LED_ADDR` (8192) and `BUT_ADDR` (8193) constants;
  - the `rx_state_t` enum (IDLE, START, DATA, STOP).
- Sub-module `uart_rx_byte` contains:
  - the synchronizer, FSM, bit/baud counters and shift register;
  - outputs `byte_valid` (1-cycle pulse), `byte_data[7:0]` and `frame_bad` (1-cycle pulse).
- The top level holds word assembly, the address counter and the flags.

## Test plan
Bench uses `CLKS_PER_BIT`=8 and `RAM_WORDS`=4.
- Reset then `start`; send 0x12, 0x34 → one `load` with `address`=0 and `dataW`=0x1234; `address` reads 1 on the next cycle.
- Send 0xAB, then 0xCD with a low stop bit, then 0xEF, 0x01 → `frame_err`=1; a single `load` with `dataW`=0xEF01 at `address`=0.
- Send 4 words (0x0001..0x0004), then 0xFF, 0xFF → 4 `load`s at addresses 0..3; `full`=1, `active`=0, `address`=3; the fifth word causes no `load`.
- Low glitch on `rx` of 3 cycles while idle → no byte, no `load`, no `frame_err`.
- Send 0x55 (HIGH byte), pulse `start`, send 0x66, 0x77 → `load` at `address`=0 with `dataW`=0x6677.
- Assert `rst_n`=0 mid-DATA, release it, send 0x80, 0x00 after `start` → outputs are at reset values during reset; one `load` with `dataW`=0x8000 at `address`=0.
